// File: rtl/pipelined_mux_nx1.sv
// pipelined_mux_nx1
//   Two-stage pipelined N:1 word multiplexer with valid/ready flow control.
//   Stage 1 registers the N/2 first-level pair-mux results (chosen by
//   in_sel[0]) together with the select. Stage 2 finishes the selection
//   with the upper select bits and registers the word on the output.
//   Either stage may advance into a hole or behind a consumed result, so
//   the pipe streams one result per cycle and stalls without loss.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   flush      synchronous clear of both valid bits; blocks acceptance
//   in_valid   upstream offers a transaction
//   in_ready   transaction is accepted this cycle when in_valid is high
//   in_data    N channels, channel k at bits [k*WIDTH +: WIDTH]
//   in_sel     channel index to forward
//   out_valid  out_data/out_sel hold a result
//   out_ready  downstream consumes the result this cycle
//   out_data   selected channel word
//   out_sel    in_sel value that produced out_data
module pipelined_mux_nx1 #(
  parameter  int WIDTH = 64,
  parameter  int N     = 4,
  localparam int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [SELW-1:0]      in_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel
);

  localparam int HALF = N / 2;

  generate
    if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
      $error("pipelined_mux_nx1: N must be a power of 2 and >= 2");
    end
    if (WIDTH < 1) begin : g_bad_width
      $error("pipelined_mux_nx1: WIDTH must be >= 1");
    end
  endgenerate

  logic                 r_vld_p1;
  logic [WIDTH-1:0]     r_pair_p1 [HALF];
  logic [SELW-1:0]      r_sel_p1;
  logic                 r_vld_p2;
  logic [WIDTH-1:0]     r_data_p2;
  logic [SELW-1:0]      r_sel_p2;

  logic                 w_adv1;
  logic                 w_adv2;
  logic                 w_ld1;
  logic                 w_ld2;
  logic [WIDTH-1:0]     w_pair_p0 [HALF];
  logic [SELW-1:0]      w_hi_sel_p1;
  logic [WIDTH-1:0]     w_word_p1;

  // A stage advances when it is empty or the stage after it is moving.
  assign w_adv2   = !r_vld_p2 || out_ready;
  assign w_adv1   = !r_vld_p1 || w_adv2;
  assign in_ready = w_adv1 && !flush;

  // Data words only load when a real transaction moves in, so the wide
  // registers stay quiet during bubbles, stalls and flushes.
  assign w_ld1 = w_adv1 && !flush && in_valid;
  assign w_ld2 = w_adv2 && !flush && r_vld_p1;

  // ---- stage 0 -> 1 : first-level pair muxes on in_sel[0]
  always_comb begin
    for (int j = 0; j < HALF; j++) begin
      w_pair_p0[j] = in_sel[0] ? in_data[(2*j+1)*WIDTH +: WIDTH]
                               : in_data[(2*j)*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < HALF; j++) begin
        r_pair_p1[j] <= '0;
      end
      r_sel_p1 <= '0;
    end else if (w_ld1) begin
      for (int j = 0; j < HALF; j++) begin
        r_pair_p1[j] <= w_pair_p0[j];
      end
      r_sel_p1 <= in_sel;
    end
  end

  // ---- stage 1 -> 2 : final selection on the upper select bits
  assign w_hi_sel_p1 = r_sel_p1 >> 1;

  always_comb begin
    w_word_p1 = r_pair_p1[0];
    for (int j = 0; j < HALF; j++) begin
      if (w_hi_sel_p1 == SELW'(j)) begin
        w_word_p1 = r_pair_p1[j];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data_p2 <= '0;
      r_sel_p2  <= '0;
    end else if (w_ld2) begin
      r_data_p2 <= w_word_p1;
      r_sel_p2  <= r_sel_p1;
    end
  end

  // ---- valid bits for both stages
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else if (flush) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      if (w_adv2) begin
        r_vld_p2 <= r_vld_p1;
      end
      if (w_adv1) begin
        r_vld_p1 <= in_valid;
      end
    end
  end

  assign out_valid = r_vld_p2;
  assign out_data  = r_data_p2;
  assign out_sel   = r_sel_p2;

endmodule

// File: tb/tb_pipelined_mux_nx1.sv
module tb_pipelined_mux_nx1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Instance A: N=4, WIDTH=8 (directed scenarios + alternating backpressure)
  logic        a_flush = 1'b0;
  logic        a_in_valid = 1'b0;
  logic        a_in_ready;
  logic [31:0] a_in_data = '0;
  logic [1:0]  a_in_sel = '0;
  logic        a_out_valid;
  logic        a_out_ready = 1'b0;
  logic [7:0]  a_out_data;
  logic [1:0]  a_out_sel;

  // Instance B: N=8, WIDTH=1 (long random run)
  logic        b_flush = 1'b0;
  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [7:0]  b_in_data = '0;
  logic [2:0]  b_in_sel = '0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;
  logic [0:0]  b_out_data;
  logic [2:0]  b_out_sel;

  pipelined_mux_nx1 #(.WIDTH(8), .N(4)) u_dut_a (
    .clk(clk), .reset(reset), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_sel(a_in_sel),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_sel(a_out_sel)
  );

  pipelined_mux_nx1 #(.WIDTH(1), .N(8)) u_dut_b (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_sel(b_in_sel),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_sel(b_out_sel)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: each accepted transaction enqueues the expected
  // {sel, word}; the word is the sel-th WIDTH-bit slice of in_data.
  // Results must leave in accept order, each exactly once.
  logic [63:0] qa[$];
  logic [63:0] qb[$];
  int nacc_b = 0;

  always @(negedge reset) begin
    qa.delete();
    qb.delete();
  end

  always @(posedge clk) begin
    logic [63:0] e;
    if (!reset || a_flush) begin
      qa.delete();
    end else begin
      if (a_out_valid && a_out_ready) begin
        chk("a_q_nonempty", 64'(qa.size() != 0), 64'd1);
        if (qa.size() != 0) begin
          chk("a_out", {54'd0, a_out_sel, a_out_data}, qa.pop_front());
        end
      end
      if (a_in_valid && a_in_ready) begin
        e = 64'((a_in_data >> (32'(a_in_sel) * 8)) & 32'hFF);
        e = e | (64'(a_in_sel) << 8);
        qa.push_back(e);
      end
    end
    if (!reset || b_flush) begin
      qb.delete();
    end else begin
      if (b_out_valid && b_out_ready) begin
        chk("b_q_nonempty", 64'(qb.size() != 0), 64'd1);
        if (qb.size() != 0) begin
          chk("b_out", {60'd0, b_out_sel, b_out_data}, qb.pop_front());
        end
      end
      if (b_in_valid && b_in_ready) begin
        e = 64'((b_in_data >> b_in_sel) & 8'h01);
        e = e | (64'(b_in_sel) << 1);
        qb.push_back(e);
        nacc_b++;
      end
    end
  end

  initial begin
    int cyc;

    // Reset state
    repeat (2) step();
    chk("rst_a_vld", 64'(a_out_valid), 64'd0);
    chk("rst_a_data", 64'(a_out_data), 64'd0);
    chk("rst_a_sel", 64'(a_out_sel), 64'd0);
    chk("rst_b_vld", 64'(b_out_valid), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_rel_ready", 64'(a_in_ready), 64'd1);
    step();
    chk("rst_rel_ready2", 64'(a_in_ready), 64'd1);

    // Back-to-back selects 0..3, no backpressure, 2-cycle latency
    a_in_data   = 32'h4433_2211;
    a_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        a_in_valid = 1'b1;
        a_in_sel   = 2'(i);
      end else begin
        a_in_valid = 1'b0;
      end
      step();
      if (i >= 1 && i <= 4) begin
        chk("b2b_vld", 64'(a_out_valid), 64'd1);
        chk("b2b_data", 64'(a_out_data), 64'(8'h11 * i));
        chk("b2b_sel", 64'(a_out_sel), 64'(i - 1));
      end
      if (i == 5) chk("b2b_drained", 64'(a_out_valid), 64'd0);
    end

    // Fill, stall 5 cycles, then release
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_sel    = 2'd2;
    step();
    a_in_sel    = 2'd1;
    step();
    chk("full_ready", 64'(a_in_ready), 64'd0);
    chk("full_data", 64'(a_out_data), 64'h33);
    a_in_sel = 2'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_ready", 64'(a_in_ready), 64'd0);
      chk("stall_data", 64'(a_out_data), 64'h33);
      chk("stall_sel", 64'(a_out_sel), 64'd2);
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    step();
    chk("rel_vld", 64'(a_out_valid), 64'd1);
    chk("rel_data", 64'(a_out_data), 64'h22);
    chk("rel_sel", 64'(a_out_sel), 64'd1);
    step();
    chk("rel_empty", 64'(a_out_valid), 64'd0);

    // Flush with both stages full
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_sel    = 2'd0;
    step();
    a_in_sel    = 2'd3;
    step();
    chk("pre_flush_vld", 64'(a_out_valid), 64'd1);
    a_flush  = 1'b1;
    a_in_sel = 2'd1;
    #1;
    chk("flush_ready", 64'(a_in_ready), 64'd0);
    step();
    chk("flush_vld", 64'(a_out_valid), 64'd0);
    a_flush     = 1'b0;
    a_in_sel    = 2'd2;
    a_out_ready = 1'b1;
    #1;
    chk("post_flush_ready", 64'(a_in_ready), 64'd1);
    step();
    a_in_valid = 1'b0;
    chk("post_flush_lat1", 64'(a_out_valid), 64'd0);
    step();
    chk("post_flush_vld", 64'(a_out_valid), 64'd1);
    chk("post_flush_data", 64'(a_out_data), 64'h33);
    chk("post_flush_sel", 64'(a_out_sel), 64'd2);
    step();
    chk("post_flush_empty", 64'(a_out_valid), 64'd0);

    // Asynchronous reset while a result is held
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_sel    = 2'd3;
    step();
    a_in_valid  = 1'b0;
    step();
    chk("pre_arst_vld", 64'(a_out_valid), 64'd1);
    chk("pre_arst_data", 64'(a_out_data), 64'h44);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_vld", 64'(a_out_valid), 64'd0);
    chk("arst_data", 64'(a_out_data), 64'd0);
    chk("arst_sel", 64'(a_out_sel), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    a_out_ready = 1'b1;
    #1;
    chk("arst_rel_ready", 64'(a_in_ready), 64'd1);
    step();
    chk("arst_gone1", 64'(a_out_valid), 64'd0);
    step();
    chk("arst_gone2", 64'(a_out_valid), 64'd0);

    // Alternating out_ready with in_valid held high, random data/sel
    for (int i = 0; i < 40; i++) begin
      a_in_valid  = 1'b1;
      a_in_data   = $urandom;
      a_in_sel    = 2'($urandom);
      a_out_ready = (i % 2 == 0);
      step();
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    repeat (4) step();
    chk("alt_drained", 64'(qa.size()), 64'd0);
    chk("alt_out_idle", 64'(a_out_valid), 64'd0);

    // Random traffic on the 8-channel, 1-bit instance
    cyc = 0;
    while (nacc_b < 1000 && cyc < 20000) begin
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_in_data   = 8'($urandom);
      b_in_sel    = 3'($urandom);
      b_out_ready = ($urandom_range(0, 3) != 0);
      step();
      cyc++;
    end
    chk("b_accepts", 64'(nacc_b), 64'd1000);
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    repeat (4) step();
    chk("b_drained", 64'(qb.size()), 64'd0);
    chk("b_out_idle", 64'(b_out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
